// File: rtl/spart_driver.sv
`default_nettype none
// ============================================================================
// Module   : spart_driver
// Purpose  : Processor-side bus master for the spart serial block. Programs
//            the baud divisor after reset and whenever br_cfg changes, then
//            bridges an upstream byte stream (valid/ready) to the spart
//            transmit buffer and forwards received bytes as rx_valid pulses.
//            It stands in for a CPU during standalone board bring-up.
//
// Ports    : clk       system clock, rising edge
//            rst       synchronous active-high reset
//            br_cfg    baud select 00=4800 01=9600 10=19200 11=38400
//            iorw      1=read, 0=write
//            ioaddr    00=TX/RX buf, 01=status, 10=div low, 11=div high
//            databus   bidirectional, driven only in write states
//            rda, tbr  spart receive-available / transmit-ready status
//            tx_valid, tx_data, tx_ready   upstream byte handshake
//            rx_valid, rx_data             received byte output
//
// Options  : define SPART_DRV_ECHO_EN to loop every received byte back to
//            the transmitter (echo has priority over the upstream stream).
//
// Revision : 1.0  initial release
// ============================================================================
module spart_driver #(
  parameter int unsigned CLK_FREQ = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  output logic       iorw,
  output logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  input  logic       rda,
  input  logic       tbr,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data
);

  // --------------------------------------------------------------------------
  // Divisor table, computed at elaboration from the clock frequency
  // --------------------------------------------------------------------------
  function automatic logic [15:0] calc_div(input longint unsigned baud);
    longint unsigned q;
    q = 64'(CLK_FREQ) / (64'd16 * baud);
    return 16'(q - 64'd1);
  endfunction

  localparam logic [15:0] C_DIV_4800  = calc_div(64'd4800);
  localparam logic [15:0] C_DIV_9600  = calc_div(64'd9600);
  localparam logic [15:0] C_DIV_19200 = calc_div(64'd19200);
  localparam logic [15:0] C_DIV_38400 = calc_div(64'd38400);

  localparam logic [1:0] C_ADDR_BUF    = 2'b00;
  localparam logic [1:0] C_ADDR_STATUS = 2'b01;
  localparam logic [1:0] C_ADDR_DBL    = 2'b10;
  localparam logic [1:0] C_ADDR_DBH    = 2'b11;

  function automatic logic [15:0] div_of(input logic [1:0] sel);
    logic [15:0] d;
    case (sel)
      2'b00:   d = C_DIV_4800;
      2'b01:   d = C_DIV_9600;
      2'b10:   d = C_DIV_19200;
      default: d = C_DIV_38400;
    endcase
    return d;
  endfunction

  // --------------------------------------------------------------------------
  // State and registers
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_WR_DBL  = 3'd0,
    S_WR_DBH  = 3'd1,
    S_IDLE    = 3'd2,
    S_RD_RX   = 3'd3,
    S_WR_TX   = 3'd4,
    S_TX_WAIT = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  cfg_q, cfg_d;        // baud select currently programmed
  logic        wait_q, wait_d;      // set once TX_WAIT has spent one cycle
  logic        rx_valid_q;
  logic [7:0]  rx_data_q;
  logic        rx_capture;          // RD_RX: sample databus at cycle end

  logic [15:0] div_live;            // divisor for the incoming br_cfg
  logic [15:0] div_cfg;             // divisor for the latched cfg_q
  logic        drv_en;
  logic [7:0]  drv_byte;

`ifdef SPART_DRV_ECHO_EN
  logic        echo_pend_q;
  logic [7:0]  echo_q;
  logic        echo_src_q, echo_src_d;  // current WR_TX carries the echo byte
`endif

  assign div_live = div_of(br_cfg);
  assign div_cfg  = div_of(cfg_q);

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    wait_d     = wait_q;
    iorw       = 1'b1;
    ioaddr     = C_ADDR_STATUS;
    drv_en     = 1'b0;
    drv_byte   = 8'h00;
    tx_ready   = 1'b0;
    rx_capture = 1'b0;
`ifdef SPART_DRV_ECHO_EN
    echo_src_d = echo_src_q;
`endif

    case (state_q)
      S_WR_DBL: begin
        iorw     = 1'b0;
        ioaddr   = C_ADDR_DBL;
        drv_en   = 1'b1;
        drv_byte = div_live[7:0];
        cfg_d    = br_cfg;
        state_d  = S_WR_DBH;
      end

      S_WR_DBH: begin
        iorw     = 1'b0;
        ioaddr   = C_ADDR_DBH;
        drv_en   = 1'b1;
        drv_byte = div_cfg[15:8];
        state_d  = S_IDLE;
      end

      S_IDLE: begin
        // Reprogramming beats receive, receive beats transmit.
        if (br_cfg != cfg_q) begin
          state_d = S_WR_DBL;
        end else if (rda) begin
          state_d = S_RD_RX;
`ifdef SPART_DRV_ECHO_EN
        end else if (echo_pend_q && tbr) begin
          state_d    = S_WR_TX;
          echo_src_d = 1'b1;
`endif
        end else if (tx_valid && tbr) begin
          state_d = S_WR_TX;
`ifdef SPART_DRV_ECHO_EN
          echo_src_d = 1'b0;
`endif
        end
      end

      S_RD_RX: begin
        ioaddr     = C_ADDR_BUF;
        rx_capture = 1'b1;
        state_d    = S_IDLE;
      end

      S_WR_TX: begin
        iorw    = 1'b0;
        ioaddr  = C_ADDR_BUF;
        drv_en  = 1'b1;
`ifdef SPART_DRV_ECHO_EN
        drv_byte = echo_src_q ? echo_q : tx_data;
        tx_ready = ~echo_src_q;
`else
        drv_byte = tx_data;
        tx_ready = 1'b1;
`endif
        wait_d  = 1'b0;
        state_d = S_TX_WAIT;
      end

      S_TX_WAIT: begin
        // tbr may lag the write; leave as soon as it drops, or after two
        // cycles if the spart never showed it low.
        if (!tbr || wait_q) begin
          state_d = S_IDLE;
        end else begin
          wait_d = 1'b1;
        end
      end

      default: begin
        state_d = S_WR_DBL;
      end
    endcase

    // During reset the bus is released and no handshake is given, whatever
    // state the machine was in when reset arrived.
    if (rst) begin
      iorw       = 1'b1;
      ioaddr     = C_ADDR_STATUS;
      drv_en     = 1'b0;
      tx_ready   = 1'b0;
      rx_capture = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_WR_DBL;
      cfg_q      <= 2'b00;
      wait_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      wait_q     <= wait_d;
      rx_valid_q <= rx_capture;
      if (rx_capture) begin
        rx_data_q <= databus;
      end
    end
  end

`ifdef SPART_DRV_ECHO_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      echo_pend_q <= 1'b0;
      echo_q      <= 8'h00;
      echo_src_q  <= 1'b0;
    end else begin
      echo_src_q <= echo_src_d;
      if (rx_capture) begin
        // Latest received byte wins if an echo is still outstanding.
        echo_pend_q <= 1'b1;
        echo_q      <= databus;
      end else if (state_q == S_WR_TX && echo_src_q) begin
        echo_pend_q <= 1'b0;
      end
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Bus and output drive
  // --------------------------------------------------------------------------
  assign databus  = drv_en ? drv_byte : 8'hzz;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;

endmodule
`default_nettype wire
